id_issue_ctrl: RTL and testbench
================================

# id_issue_ctrl

Issue/interlock controller for the decode stage of the five-stage LoongArch pipeline. It keeps a three-slot scoreboard of register writes in flight in EX, MEM and WB. Using that scoreboard, it decides each cycle whether the instruction in ID may issue to EX or must stall. It also qualifies branch redirects so they take effect only for issued instructions, and it keeps stall and issue performance counters. The pipeline has no forwarding network, so this block is the only guard against RAW hazards.

## Interface
- `SLOTS`, default 3: scoreboard depth (EX, MEM, WB). Fixed at 3 in this core.
- `SCNT_W`, default 16: width of the saturating stall counter.
- `clk` in 1: core clock.
- `resetn` in 1: reset, asynchronous assert, active-low.
- `id_valid` in 1: ID holds a valid instruction.
- `id_rj` in 5: first source register.
- `id_rj_used` in 1: the instruction reads `id_rj`.
- `id_rkd` in 5: second source register (rk or rd).
- `id_rkd_used` in 1: the instruction reads `id_rkd`.
- `id_gr_we` in 1: the instruction writes a GPR.
- `id_dest` in 5: destination GPR.
- `id_br_taken` in 1: branch/jump resolved taken in ID.
- `ex_allowin` in 1: EX and the stages downstream can advance this cycle.
- `id_allowin` out 1: ID may accept a new instruction from IF.
- `id_to_ex_valid` out 1: issue fires this cycle.
- `br_taken_q` out 1: qualified redirect to IF.
- `sb_valid` out 3: pending-write valid bits, ordered [WB, MEM, EX].
- `state` out 2: controller state.
- `stall_cnt` out `SCNT_W`: stall-cycle counter, saturating.
- `issue_cnt` out 32: issued-instruction counter, wraps.

## Operation
- Each scoreboard slot holds `{v, dest[4:0]}`. When an instruction issues, it is written into the EX slot with `v = id_gr_we & (id_dest != 0)`.
- Hazard on a source: the source is used, it is not r0, and it matches any slot with `v = 1`. `hazard` is the OR over both sources and all three slots.
- `stall = id_valid & hazard`.
- `issue = id_valid & ~hazard & ex_allowin`.
- `id_to_ex_valid = issue`.
- `id_allowin = ~id_valid | issue`.
- `br_taken_q = id_br_taken & issue`. A branch that is stalled does not redirect.
- Scoreboard advance happens when `ex_allowin = 1`:
  - WB ← MEM, MEM ← EX.
  - EX ← the issuing instruction, or a bubble (`v = 0`) if nothing issues.
  - The old WB entry retires, because its regfile write completes at this edge.
- When `ex_allowin = 0`, all slots hold.
- Matching against the WB slot is mandatory. The regfile is read-before-write within a cycle, so a value being written in WB is not yet visible to ID.
- State machine, `state` encoding: IDLE = 0, RUN = 1, STALL = 2.
  - IDLE → RUN on the first cycle with `id_valid = 1`.
  - RUN → STALL when `stall = 1`.
  - STALL → RUN when `stall = 0`.
  - RUN or STALL → IDLE when `id_valid = 0` and `sb_valid = 0`.
  - Next state is registered; `state` shows the current cycle's classification from the previous edge.
- `stall_cnt` increments every cycle with `stall = 1` and saturates at all-ones.
- `issue_cnt` increments on each issue and wraps modulo 2^32.

## Timing
- `stall`, `id_allowin`, `id_to_ex_valid` and `br_taken_q` are combinational from the ID inputs and the scoreboard registers. There are no registered outputs in this path, so the latency from a dependency to a stall is 0 cycles.
- The scoreboard, `state` and both counters update on the rising edge of `clk`.
- A dependent instruction directly behind a producer stalls for exactly 3 cycles (producer in EX, then MEM, then WB), assuming `ex_allowin` stays 1. It issues on the 4th cycle.
- Reset (`resetn = 0`), applied at any time, including mid-stall:
  - All slot `v` bits clear, `state` = IDLE, both counters = 0, asynchronously.
  - While in reset, `stall = 0`, and `id_allowin` is 1 when `id_valid = 0`.
  - `br_taken_q = 0` unless an issue fires.
- Simultaneous events:
  - An issue into EX while a matching dest retires from WB on the same edge: the new entry wins, and the retiring entry is gone.
  - `ex_allowin = 0` with no hazard: no issue, and the slots hold.
  - Both sources hit different slots: still a single stall.
- Writes to r0 never create an entry, and reads of r0 never hazard.

## Structure
- Shared package `core_pkg`:
  - State encodings `ST_IDLE`, `ST_RUN`, `ST_STALL`.
  - Constant `NUM_GPR = 32`.
  - Scoreboard entry typedef `sb_entry_t {v, dest}`.
- One natural sub-module, `sb_match`: a combinational compare of a 5-bit source against the three slots, instantiated twice (once per source).
- The counters and the FSM stay inline.

## Test plan
- Reset: drive `resetn = 0` mid-stall, then release → `sb_valid = 3'b000`, `state = 0`, `stall_cnt = 0`; the next `id_valid` with a prior dependency issues immediately.
- RAW chain: `add.w r5,..`, then `addi.w r6,r5,1`, with `ex_allowin = 1` → `id_to_ex_valid` low for 3 cycles and high on the 4th; `stall_cnt = 3`.
- r0 immunity: a producer writing r0, then a consumer reading r0 → no stall, and the issue fires back-to-back.
- Back-pressure: hazard pending and `ex_allowin = 0` held for 2 cycles → slots frozen, stall extends to 5 cycles total, `issue_cnt` unchanged during the freeze.
- Stalled branch: `beq` reading r7 while r7 sits in the MEM slot → `br_taken_q = 0` for 2 cycles, then 1 on the issue cycle, exactly one cycle wide.
- Saturation/wrap: preload `stall_cnt = 16'hFFFE` and `issue_cnt = 32'hFFFFFFFF` → after 3 stall cycles `stall_cnt = 16'hFFFF`; after 1 issue `issue_cnt = 0`.

Source files
------------

// File: rtl/core_pkg.sv
// Shared decode-stage types: controller state codes and the scoreboard entry layout.
package core_pkg;

    localparam int NUM_GPR = 32;
    localparam int REG_W   = $clog2(NUM_GPR);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dest;
    } sb_entry_t;

endpackage

// File: rtl/id_issue_ctrl_sb_match.sv
// Compares one ID source register against every in-flight write in the scoreboard.
module sb_match
    import core_pkg::*;
#(
    parameter int SLOTS = 3
) (
    input  logic [REG_W-1:0]            src_i,
    input  logic                        used_i,
    input  sb_entry_t [SLOTS-1:0]       slots_i,
    output logic                        hit_o
);

    // r0 is hardwired zero, so reading it can never depend on a producer.
    always_comb begin
        hit_o = 1'b0;
        if (used_i && (src_i != '0)) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (slots_i[s].v && (slots_i[s].dest == src_i)) hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue/interlock: scoreboard of writes in EX/MEM/WB, stall/issue decision,
// branch qualification, controller state and performance counters.
module id_issue_ctrl
    import core_pkg::*;
#(
    parameter int SLOTS  = 3,
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              id_valid,
    input  logic [4:0]        id_rj,
    input  logic              id_rj_used,
    input  logic [4:0]        id_rkd,
    input  logic              id_rkd_used,
    input  logic              id_gr_we,
    input  logic [4:0]        id_dest,
    input  logic              id_br_taken,
    input  logic              ex_allowin,
    output logic              id_allowin,
    output logic              id_to_ex_valid,
    output logic              br_taken_q,
    output logic [SLOTS-1:0]  sb_valid,
    output logic [1:0]        state,
    output logic [SCNT_W-1:0] stall_cnt,
    output logic [31:0]       issue_cnt
);

    // Slot 0 = EX, 1 = MEM, SLOTS-1 = WB.
    sb_entry_t [SLOTS-1:0] sb_q, sb_d;
    logic [1:0]            state_q, state_d;
    logic [SCNT_W-1:0]     stall_cnt_q;
    logic [31:0]           issue_cnt_q;
    logic                  hit_rj, hit_rkd, hazard, stall, issue;

    sb_match #(.SLOTS(SLOTS)) u_match_rj (
        .src_i(id_rj), .used_i(id_rj_used), .slots_i(sb_q), .hit_o(hit_rj)
    );
    sb_match #(.SLOTS(SLOTS)) u_match_rkd (
        .src_i(id_rkd), .used_i(id_rkd_used), .slots_i(sb_q), .hit_o(hit_rkd)
    );

    assign hazard         = hit_rj | hit_rkd;
    assign stall          = id_valid & hazard;
    assign issue          = id_valid & ~hazard & ex_allowin;
    assign id_to_ex_valid = issue;
    assign id_allowin     = ~id_valid | issue;
    assign br_taken_q     = id_br_taken & issue;

    // WB entry falls off the end when the pipe advances; its regfile write lands at this edge.
    always_comb begin
        sb_d = sb_q;
        if (ex_allowin) begin
            for (int s = SLOTS-1; s > 0; s--) sb_d[s] = sb_q[s-1];
            sb_d[0].v    = issue & id_gr_we & (id_dest != 5'd0);
            sb_d[0].dest = id_dest;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (id_valid) state_d = ST_RUN;
            ST_RUN:   if (stall) state_d = ST_STALL;
                      else if (!id_valid && (sb_valid == '0)) state_d = ST_IDLE;
            ST_STALL: if (!id_valid && (sb_valid == '0)) state_d = ST_IDLE;
                      else if (!stall) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_q        <= '0;
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            sb_q    <= sb_d;
            state_q <= state_d;
            if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + SCNT_W'(1);
            if (issue) issue_cnt_q <= issue_cnt_q + 32'd1;
        end
    end

    for (genvar g = 0; g < SLOTS; g++) begin : g_vld
        assign sb_valid[g] = sb_q[g].v;
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: hand-computed interlock, branch and counter expectations.
module tb_id_issue_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid, id_rj_used, id_rkd_used, id_gr_we, id_br_taken, ex_allowin;
    logic [4:0]  id_rj, id_rkd, id_dest;
    logic        id_allowin, id_to_ex_valid, br_taken_q;
    logic [2:0]  sb_valid;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [31:0] issue_cnt;

    int ncmp  = 0;
    int nfail = 0;

    id_issue_ctrl #(.SLOTS(3), .SCNT_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .id_valid(id_valid), .id_rj(id_rj), .id_rj_used(id_rj_used),
        .id_rkd(id_rkd), .id_rkd_used(id_rkd_used), .id_gr_we(id_gr_we),
        .id_dest(id_dest), .id_br_taken(id_br_taken), .ex_allowin(ex_allowin),
        .id_allowin(id_allowin), .id_to_ex_valid(id_to_ex_valid), .br_taken_q(br_taken_q),
        .sb_valid(sb_valid), .state(state), .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_id(input logic v, input logic [4:0] rj, input logic rju,
                          input logic [4:0] rkd, input logic rkdu, input logic we,
                          input logic [4:0] dst, input logic br);
        id_valid = v; id_rj = rj; id_rj_used = rju; id_rkd = rkd; id_rkd_used = rkdu;
        id_gr_we = we; id_dest = dst; id_br_taken = br;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        ex_allowin = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        ncmp++; if (sb_valid !== 3'b000) begin nfail++; $display("FAIL rst_sb: got %b want 000", sb_valid); end
        ncmp++; if (state !== 2'd0) begin nfail++; $display("FAIL rst_state: got %0d want 0", state); end
        ncmp++; if (stall_cnt !== 16'd0) begin nfail++; $display("FAIL rst_scnt: got %0d want 0", stall_cnt); end
        ncmp++; if (issue_cnt !== 32'd0) begin nfail++; $display("FAIL rst_icnt: got %0d want 0", issue_cnt); end
        ncmp++; if (id_allowin !== 1'b1) begin nfail++; $display("FAIL rst_allowin: got %b want 1", id_allowin); end
        // producer r5, consumer stalls, reset lands mid-stall
        set_id(1, 1, 1, 2, 1, 1, 5, 0);
        tick();
        set_id(1, 5, 1, 0, 0, 1, 6, 0);
        ncmp++; if (id_to_ex_valid !== 1'b0) begin nfail++; $display("FAIL mid_stall: got %b want 0", id_to_ex_valid); end
        tick();
        resetn = 1'b0;
        #1;
        ncmp++; if (sb_valid !== 3'b000) begin nfail++; $display("FAIL mid_rst_sb: got %b want 000", sb_valid); end
        ncmp++; if (state !== 2'd0) begin nfail++; $display("FAIL mid_rst_state: got %0d want 0", state); end
        ncmp++; if (stall_cnt !== 16'd0) begin nfail++; $display("FAIL mid_rst_scnt: got %0d want 0", stall_cnt); end
        set_id(0, 5, 1, 0, 0, 1, 6, 0);
        ncmp++; if (id_allowin !== 1'b1) begin nfail++; $display("FAIL rst_idle_allowin: got %b want 1", id_allowin); end
        set_id(1, 5, 1, 0, 0, 1, 6, 0);
        resetn = 1'b1;
        #1;
        ncmp++; if (id_to_ex_valid !== 1'b1) begin nfail++; $display("FAIL post_rst_issue: got %b want 1", id_to_ex_valid); end
        tick();
        ncmp++; if (issue_cnt !== 32'd1) begin nfail++; $display("FAIL post_rst_icnt: got %0d want 1", issue_cnt); end
    endtask

    task automatic test_raw_chain;
        do_reset();
        set_id(1, 1, 1, 2, 1, 1, 5, 0);
        ncmp++; if (id_to_ex_valid !== 1'b1) begin nfail++; $display("FAIL raw_prod: got %b want 1", id_to_ex_valid); end
        tick();
        set_id(1, 5, 1, 0, 0, 1, 6, 0);
        for (int i = 0; i < 3; i++) begin
            ncmp++; if (id_to_ex_valid !== 1'b0) begin nfail++; $display("FAIL raw_stall%0d: got %b want 0", i, id_to_ex_valid); end
            if (i == 0) begin
                ncmp++; if (state !== 2'd1) begin nfail++; $display("FAIL raw_state_run: got %0d want 1", state); end
            end
            if (i == 2) begin
                ncmp++; if (state !== 2'd2) begin nfail++; $display("FAIL raw_state_stall: got %0d want 2", state); end
            end
            tick();
        end
        ncmp++; if (id_to_ex_valid !== 1'b1) begin nfail++; $display("FAIL raw_issue4: got %b want 1", id_to_ex_valid); end
        ncmp++; if (stall_cnt !== 16'd3) begin nfail++; $display("FAIL raw_scnt: got %0d want 3", stall_cnt); end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ncmp++; if (issue_cnt !== 32'd2) begin nfail++; $display("FAIL raw_icnt: got %0d want 2", issue_cnt); end
        ncmp++; if (sb_valid !== 3'b001) begin nfail++; $display("FAIL raw_sb: got %b want 001", sb_valid); end
        repeat (3) tick();
        ncmp++; if (sb_valid !== 3'b000) begin nfail++; $display("FAIL raw_drain: got %b want 000", sb_valid); end
        tick();
        ncmp++; if (state !== 2'd0) begin nfail++; $display("FAIL raw_idle: got %0d want 0", state); end
    endtask

    task automatic test_r0;
        do_reset();
        set_id(1, 1, 1, 2, 1, 1, 0, 0);
        tick();
        ncmp++; if (sb_valid !== 3'b000) begin nfail++; $display("FAIL r0_sb: got %b want 000", sb_valid); end
        set_id(1, 0, 1, 0, 1, 1, 3, 0);
        ncmp++; if (id_to_ex_valid !== 1'b1) begin nfail++; $display("FAIL r0_issue: got %b want 1", id_to_ex_valid); end
        tick();
        ncmp++; if (stall_cnt !== 16'd0) begin nfail++; $display("FAIL r0_scnt: got %0d want 0", stall_cnt); end
        ncmp++; if (issue_cnt !== 32'd2) begin nfail++; $display("FAIL r0_icnt: got %0d want 2", issue_cnt); end
    endtask

    task automatic test_backpressure;
        do_reset();
        ex_allowin = 1'b0;
        set_id(1, 1, 1, 2, 1, 1, 9, 0);
        ncmp++; if (id_to_ex_valid !== 1'b0) begin nfail++; $display("FAIL bp_noissue: got %b want 0", id_to_ex_valid); end
        ncmp++; if (id_allowin !== 1'b0) begin nfail++; $display("FAIL bp_allowin: got %b want 0", id_allowin); end
        tick();
        ncmp++; if (sb_valid !== 3'b000 || stall_cnt !== 16'd0 || issue_cnt !== 32'd0) begin
            nfail++; $display("FAIL bp_hold: got sb=%b scnt=%0d icnt=%0d want 000/0/0", sb_valid, stall_cnt, issue_cnt);
        end
        ex_allowin = 1'b1;
        set_id(1, 1, 1, 2, 1, 1, 5, 0);
        tick();
        set_id(1, 2, 1, 5, 1, 1, 6, 0);
        tick();
        ex_allowin = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            ncmp++; if (id_to_ex_valid !== 1'b0 || sb_valid !== 3'b010) begin
                nfail++; $display("FAIL bp_freeze%0d: got itv=%b sb=%b want 0/010", i, id_to_ex_valid, sb_valid);
            end
            tick();
        end
        ncmp++; if (issue_cnt !== 32'd1) begin nfail++; $display("FAIL bp_icnt: got %0d want 1", issue_cnt); end
        ex_allowin = 1'b1;
        #1;
        tick();
        ncmp++; if (sb_valid !== 3'b100 || id_to_ex_valid !== 1'b0) begin
            nfail++; $display("FAIL bp_wb: got sb=%b itv=%b want 100/0", sb_valid, id_to_ex_valid);
        end
        tick();
        ncmp++; if (id_to_ex_valid !== 1'b1) begin nfail++; $display("FAIL bp_issue: got %b want 1", id_to_ex_valid); end
        ncmp++; if (stall_cnt !== 16'd5) begin nfail++; $display("FAIL bp_scnt: got %0d want 5", stall_cnt); end
        tick();
        ncmp++; if (issue_cnt !== 32'd2) begin nfail++; $display("FAIL bp_icnt2: got %0d want 2", issue_cnt); end
    endtask

    task automatic test_branch;
        do_reset();
        set_id(1, 1, 1, 2, 1, 1, 7, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 7, 1, 3, 1, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            ncmp++; if (br_taken_q !== 1'b0) begin nfail++; $display("FAIL br_stalled%0d: got %b want 0", i, br_taken_q); end
            tick();
        end
        ncmp++; if (br_taken_q !== 1'b1) begin nfail++; $display("FAIL br_issue: got %b want 1", br_taken_q); end
        tick();
        set_id(0, 7, 1, 3, 1, 0, 0, 1);
        ncmp++; if (br_taken_q !== 1'b0) begin nfail++; $display("FAIL br_width: got %b want 0", br_taken_q); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        set_id(1, 1, 1, 2, 1, 1, 5, 0);
        tick();
        set_id(1, 1, 1, 0, 0, 1, 8, 0);
        tick();
        set_id(1, 5, 1, 8, 1, 1, 4, 0);
        for (int i = 0; i < 3; i++) begin
            ncmp++; if (id_to_ex_valid !== 1'b0) begin nfail++; $display("FAIL dual_stall%0d: got %b want 0", i, id_to_ex_valid); end
            tick();
        end
        ncmp++; if (id_to_ex_valid !== 1'b1 || stall_cnt !== 16'd3) begin
            nfail++; $display("FAIL dual_issue: got itv=%b scnt=%0d want 1/3", id_to_ex_valid, stall_cnt);
        end
        // re-write of r5 on the edge where the older r5 retires from WB
        do_reset();
        set_id(1, 1, 1, 2, 1, 1, 5, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        set_id(1, 1, 1, 0, 0, 1, 5, 0);
        ncmp++; if (sb_valid !== 3'b100 || id_to_ex_valid !== 1'b1) begin
            nfail++; $display("FAIL retire_pre: got sb=%b itv=%b want 100/1", sb_valid, id_to_ex_valid);
        end
        tick();
        ncmp++; if (sb_valid !== 3'b001) begin nfail++; $display("FAIL retire_post: got %b want 001", sb_valid); end
    endtask

    task automatic test_saturation;
        do_reset();
        set_id(1, 1, 1, 2, 1, 1, 5, 0);
        tick();
        ex_allowin = 1'b0;
        set_id(1, 5, 1, 0, 0, 1, 6, 0);
        repeat (65534) tick();
        ncmp++; if (stall_cnt !== 16'hFFFE) begin nfail++; $display("FAIL sat_fffe: got %h want fffe", stall_cnt); end
        tick();
        ncmp++; if (stall_cnt !== 16'hFFFF) begin nfail++; $display("FAIL sat_ffff: got %h want ffff", stall_cnt); end
        tick();
        tick();
        ncmp++; if (stall_cnt !== 16'hFFFF) begin nfail++; $display("FAIL sat_hold: got %h want ffff", stall_cnt); end
        ncmp++; if (issue_cnt !== 32'd1) begin nfail++; $display("FAIL sat_icnt: got %0d want 1", issue_cnt); end
    endtask

    initial begin
        test_reset();
        test_raw_chain();
        test_r0();
        test_backpressure();
        test_branch();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
